// File: rtl/alu4_issue_seq_if.sv
// Bundle of the instruction, ALU and result channels of the alu4 issue sequencer.
// The sequencer uses the slave view; an upstream issuer/ALU/consumer uses the master view.
`timescale 1ns/1ps
interface alu4_issue_seq_if;
    // Instruction channel
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic [1:0] in_rt;
    logic [3:0] in_imm;

    // ALU operand and result ports
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_f;
    logic       alu_zero;
    logic       alu_overflow;

    // Result channel
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_f;
    logic       res_zero;
    logic       res_overflow;
    logic       res_err;

    // Register-file debug read port
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_imm,
        input  in_ready,
        input  alu_a, alu_b, alu_op,
        output alu_f, alu_zero, alu_overflow,
        input  res_valid, res_f, res_zero, res_overflow, res_err,
        output res_ready,
        output dbg_sel,
        input  dbg_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm,
        output in_ready,
        output alu_a, alu_b, alu_op,
        input  alu_f, alu_zero, alu_overflow,
        output res_valid, res_f, res_zero, res_overflow, res_err,
        input  res_ready,
        input  dbg_sel,
        output dbg_data
    );
endinterface

// File: rtl/alu4_issue_seq.sv
// Issue/writeback sequencer for the 4-bit combinational ALU: IDLE -> EXEC -> DONE,
// one instruction in flight, operands from a 4x4 register file, result written back.
`timescale 1ns/1ps
module alu4_issue_seq #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu4_issue_seq_if.slave    bus,
    output logic [1:0]         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high exactly in IDLE; res_valid is high exactly in DONE, and the
    // result fields stay stable until the consumer takes them with res_ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [1:0]     rd_q, rd_d;
    logic [1:0]     rs_q, rs_d;
    logic [1:0]     rt_q, rt_d;
    logic [W-1:0]   imm_q, imm_d;
    logic [W-1:0]   rf_q [NREG];
    logic [W-1:0]   rf_d [NREG];
    logic [W-1:0]   res_f_q, res_f_d;
    logic           res_zero_q, res_zero_d;
    logic           res_ovf_q, res_ovf_d;
    logic           res_err_q, res_err_d;

    logic           is_alu_op;
    logic           is_ldi;

    always_comb begin
        is_alu_op = 1'b0;
        is_ldi    = 1'b0;
        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_alu_op = 1'b1;
            OP_LDI:                                is_ldi    = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        imm_d      = imm_q;
        rf_d       = rf_q;
        res_f_d    = res_f_q;
        res_zero_d = res_zero_q;
        res_ovf_d  = res_ovf_q;
        res_err_d  = res_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_op;
                    rd_d    = bus.in_rd;
                    rs_d    = bus.in_rs;
                    rt_d    = bus.in_rt;
                    imm_d   = bus.in_imm;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Operands were read from the old rf contents this cycle, so rd==rs/rt is safe.
                if (is_alu_op) begin
                    rf_d[rd_q] = bus.alu_f;
                    res_f_d    = bus.alu_f;
                    res_zero_d = bus.alu_zero;
                    res_ovf_d  = bus.alu_overflow;
                    res_err_d  = 1'b0;
                end else if (is_ldi) begin
                    rf_d[rd_q] = imm_q;
                    res_f_d    = imm_q;
                    res_zero_d = (imm_q == '0);
                    res_ovf_d  = 1'b0;
                    res_err_d  = 1'b0;
                end else begin
                    res_f_d    = '0;
                    res_zero_d = 1'b0;
                    res_ovf_d  = 1'b0;
                    res_err_d  = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 3'b000;
            rd_q       <= 2'd0;
            rs_q       <= 2'd0;
            rt_q       <= 2'd0;
            imm_q      <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            res_f_q    <= '0;
            res_zero_q <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            imm_q      <= imm_d;
            rf_q       <= rf_d;
            res_f_q    <= res_f_d;
            res_zero_q <= res_zero_d;
            res_ovf_q  <= res_ovf_d;
            res_err_q  <= res_err_d;
        end
    end

    // The ALU only ever sees a decodable opcode, and only while an ALU op is executing.
    always_comb begin
        bus.alu_a  = rf_q[rs_q];
        bus.alu_b  = rf_q[rt_q];
        bus.alu_op = (state_q == S_EXEC && is_alu_op) ? op_q : 3'b000;
    end

    always_comb begin
        bus.in_ready     = (state_q == S_IDLE);
        bus.res_valid    = (state_q == S_DONE);
        bus.res_f        = res_f_q;
        bus.res_zero     = res_zero_q;
        bus.res_overflow = res_ovf_q;
        bus.res_err      = res_err_q;
        bus.dbg_data     = rf_q[bus.dbg_sel];
        dbg_state        = state_q;
    end

endmodule

// File: tb/tb_alu4_issue_seq.sv
// Directed bench for alu4_issue_seq: drives instructions, models the alu4 combinationally,
// and checks handshake timing, results and register-file contents against hand values.
`timescale 1ns/1ps
module tb_alu4_issue_seq;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    alu4_issue_seq_if ifc ();

    alu4_issue_seq #(.NREG(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- alu4 model ----------------
    logic [4:0] sum5;
    logic [4:0] dif5;
    always_comb begin
        sum5 = {1'b0, ifc.alu_a} + {1'b0, ifc.alu_b};
        dif5 = {1'b0, ifc.alu_a} - {1'b0, ifc.alu_b};
        ifc.alu_overflow = 1'b0;
        case (ifc.alu_op)
            3'b000:  ifc.alu_f = ifc.alu_a & ifc.alu_b;
            3'b001:  ifc.alu_f = ifc.alu_a | ifc.alu_b;
            3'b010:  begin ifc.alu_f = sum5[3:0]; ifc.alu_overflow = sum5[4]; end
            3'b110:  begin ifc.alu_f = dif5[3:0]; ifc.alu_overflow = dif5[4]; end
            3'b111:  ifc.alu_f = (ifc.alu_a < ifc.alu_b) ? 4'd1 : 4'd0;
            default: ifc.alu_f = 4'd0;
        endcase
        ifc.alu_zero = (ifc.alu_f == 4'd0);
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    logic [3:0] ex_a, ex_b;
    logic [2:0] ex_op;
    logic       ex_ready;

    // Issues one instruction from IDLE and returns just after the edge that enters DONE.
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [3:0] imm);
        int guard;
        guard = 0;
        while (!ifc.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 8'd0, 8'd1);
        ifc.in_op    = op;
        ifc.in_rd    = rd;
        ifc.in_rs    = rs;
        ifc.in_rt    = rt;
        ifc.in_imm   = imm;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        ex_a     = ifc.alu_a;
        ex_b     = ifc.alu_b;
        ex_op    = ifc.alu_op;
        ex_ready = ifc.in_ready;
        @(posedge clk); #1;
    endtask

    task automatic take_result();
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [3:0] f, input logic z,
                             input logic o, input logic e);
        @(negedge clk);
        check({tag, "_valid"}, {7'd0, ifc.res_valid}, 8'd1);
        check({tag, "_f"},     {4'd0, ifc.res_f}, {4'd0, f});
        check({tag, "_zero"},  {7'd0, ifc.res_zero}, {7'd0, z});
        check({tag, "_ovf"},   {7'd0, ifc.res_overflow}, {7'd0, o});
        check({tag, "_err"},   {7'd0, ifc.res_err}, {7'd0, e});
    endtask

    task automatic check_rf(input string tag, input logic [1:0] sel, input logic [3:0] exp);
        ifc.dbg_sel = sel;
        #1;
        check(tag, {4'd0, ifc.dbg_data}, {4'd0, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_op     = 3'b000;
        ifc.in_rd     = 2'd0;
        ifc.in_rs     = 2'd0;
        ifc.in_rt     = 2'd0;
        ifc.in_imm    = 4'd0;
        ifc.res_ready = 1'b0;
        ifc.dbg_sel   = 2'd0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 4; i++) check_rf($sformatf("rst_rf%0d", i), i[1:0], 4'd0);
        check("rst_in_ready",  {7'd0, ifc.in_ready}, 8'd1);
        check("rst_res_valid", {7'd0, ifc.res_valid}, 8'd0);
        check("rst_res_f",     {4'd0, ifc.res_f}, 8'd0);
        check("rst_res_flags", {5'd0, ifc.res_zero, ifc.res_overflow, ifc.res_err}, 8'd0);
        check("rst_alu_op",    {5'd0, ifc.alu_op}, 8'd0);
        check("rst_state",     {6'd0, dbg_state}, 8'd0);
        @(posedge clk); #1;

        // LDI r1=9, LDI r2=8
        send(3'b011, 2'd1, 2'd0, 2'd0, 4'd9);
        check("ldi_alu_op", {5'd0, ex_op}, 8'd0);
        check("ldi_exec_in_ready", {7'd0, ex_ready}, 8'd0);
        check_res("ldi9", 4'd9, 1'b0, 1'b0, 1'b0);
        take_result();
        check_rf("rf_r1_9", 2'd1, 4'd9);
        send(3'b011, 2'd2, 2'd0, 2'd0, 4'd8);
        take_result();
        check_rf("rf_r2_8", 2'd2, 4'd8);

        // ADD r3 = r1 + r2 = 9+8 -> 1 carry 1
        send(3'b010, 2'd3, 2'd1, 2'd2, 4'd0);
        check("add_alu_a",  {4'd0, ex_a}, 8'd9);
        check("add_alu_b",  {4'd0, ex_b}, 8'd8);
        check("add_alu_op", {5'd0, ex_op}, 8'h02);
        check_res("add", 4'd1, 1'b0, 1'b1, 1'b0);
        take_result();
        check_rf("rf_r3_add", 2'd3, 4'd1);

        // SUB r0 = r2 - r1 = 8-9 -> 15 borrow 1
        send(3'b110, 2'd0, 2'd2, 2'd1, 4'd0);
        check("sub_alu_op", {5'd0, ex_op}, 8'h06);
        check_res("sub_neg", 4'd15, 1'b0, 1'b1, 1'b0);
        take_result();
        check_rf("rf_r0_sub", 2'd0, 4'd15);

        // SUB r0 = r1 - r1 -> 0, zero
        send(3'b110, 2'd0, 2'd1, 2'd1, 4'd0);
        check_res("sub_zero", 4'd0, 1'b1, 1'b0, 1'b0);
        take_result();

        // SLT r3 = r2 < r1 (8 < 9) -> 1
        send(3'b111, 2'd3, 2'd2, 2'd1, 4'd0);
        check_res("slt", 4'd1, 1'b0, 1'b0, 1'b0);
        take_result();

        // AND r3 = r1 & r2 = 9 & 8 -> 8
        send(3'b000, 2'd3, 2'd1, 2'd2, 4'd0);
        check_res("and", 4'd8, 1'b0, 1'b0, 1'b0);
        take_result();
        check_rf("rf_r3_and", 2'd3, 4'd8);

        // OR of 5 and A -> F
        send(3'b011, 2'd1, 2'd0, 2'd0, 4'd5);
        take_result();
        send(3'b011, 2'd2, 2'd0, 2'd0, 4'hA);
        take_result();
        send(3'b001, 2'd3, 2'd1, 2'd2, 4'd0);
        check_res("or", 4'd15, 1'b0, 1'b0, 1'b0);
        take_result();

        // LDI of zero sets the zero flag
        send(3'b011, 2'd0, 2'd0, 2'd0, 4'd0);
        check_res("ldi0", 4'd0, 1'b1, 1'b0, 1'b0);
        take_result();

        // Illegal opcode 100 targeting r1 (=5): error, no write, ALU sees 000
        send(3'b100, 2'd1, 2'd2, 2'd3, 4'd7);
        check("ill_alu_op", {5'd0, ex_op}, 8'd0);
        check_res("ill", 4'd0, 1'b0, 1'b0, 1'b1);
        take_result();
        check_rf("rf_r1_ill", 2'd1, 4'd5);
        send(3'b101, 2'd2, 2'd0, 2'd0, 4'd1);
        check("ill101_alu_op", {5'd0, ex_op}, 8'd0);
        check_res("ill101", 4'd0, 1'b0, 1'b0, 1'b1);
        take_result();
        check_rf("rf_r2_ill", 2'd2, 4'hA);

        // Hazard: ADD r1 = r1 + r1 reads old 5, writes 10
        send(3'b010, 2'd1, 2'd1, 2'd1, 4'd0);
        check("haz_alu_a", {4'd0, ex_a}, 8'd5);
        check_res("haz", 4'd10, 1'b0, 1'b0, 1'b0);
        take_result();
        check_rf("rf_r1_haz", 2'd1, 4'd10);

        // Back-to-back with res_ready tied high: accept every 3rd cycle
        ifc.in_op     = 3'b011;
        ifc.in_rd     = 2'd0;
        ifc.in_imm    = 4'd3;
        ifc.res_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("b2b_in_ready%0d", i), {7'd0, ifc.in_ready},
                  (i % 3 == 0) ? 8'd1 : 8'd0);
            check($sformatf("b2b_res_valid%0d", i), {7'd0, ifc.res_valid},
                  (i % 3 == 2) ? 8'd1 : 8'd0);
        end
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        check_rf("rf_r0_b2b", 2'd0, 4'd3);

        // Hold in DONE for 5 cycles with res_ready=0 and a competing instruction offered
        send(3'b011, 2'd2, 2'd0, 2'd0, 4'd7);
        ifc.in_op    = 3'b011;
        ifc.in_rd    = 2'd2;
        ifc.in_imm   = 4'd1;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid%0d", i), {7'd0, ifc.res_valid}, 8'd1);
            check($sformatf("hold_in_ready%0d", i), {7'd0, ifc.in_ready}, 8'd0);
            check($sformatf("hold_f%0d", i), {4'd0, ifc.res_f}, 8'd7);
        end
        ifc.in_valid = 1'b0;
        take_result();
        @(negedge clk);
        check("hold_idle_in_ready", {7'd0, ifc.in_ready}, 8'd1);
        check("hold_idle_res_valid", {7'd0, ifc.res_valid}, 8'd0);
        check("hold_res_f_kept", {4'd0, ifc.res_f}, 8'd7);
        check_rf("rf_r2_hold", 2'd2, 4'd7);
        @(posedge clk); #1;

        // Reset asserted during EXEC abandons the instruction
        ifc.in_op    = 3'b011;
        ifc.in_rd    = 2'd3;
        ifc.in_imm   = 4'd6;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_state_exec", {6'd0, dbg_state}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("rst_exec_state", {6'd0, dbg_state}, 8'd0);
        check("rst_exec_in_ready", {7'd0, ifc.in_ready}, 8'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_exec_res_valid", {7'd0, ifc.res_valid}, 8'd0);
        check("rst_exec_res_f", {4'd0, ifc.res_f}, 8'd0);
        check("rst_exec_flags", {5'd0, ifc.res_zero, ifc.res_overflow, ifc.res_err}, 8'd0);
        for (int i = 0; i < 4; i++) check_rf($sformatf("rst_exec_rf%0d", i), i[1:0], 4'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_exec_stays_idle", {6'd0, dbg_state}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu4_issue_seq.md
Name: alu4_issue_seq

Overview:
- Multi-cycle issue/writeback sequencer that sits directly upstream of the 4-bit combinational ALU (alu4) and feeds it.
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 4x4-bit register file.
- Drives the ALU operand/opcode ports, samples the ALU result and flags, writes the result back, and presents it on a valid/ready result channel.
- Never presents an opcode the ALU does not decode.

Parameters:
- NREG, 4, number of register-file entries (index width fixed at 2; NREG must be 4).
- W, 4, data width; matches the ALU and is fixed at 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept an instruction.
- in_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 LDI, 100/101 illegal.
- in_rd  in  2  destination register.
- in_rs  in  2  operand A register.
- in_rt  in  2  operand B register.
- in_imm  in  4  immediate, used by LDI only.
- alu_a  out  4  ALU operand a.
- alu_b  out  4  ALU operand b.
- alu_op  out  3  ALU opcode.
- alu_f  in  4  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU carry/borrow bit.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_f  out  4  registered result.
- res_zero  out  1  registered zero flag.
- res_overflow  out  1  registered carry/borrow flag.
- res_err  out  1  instruction was illegal.
- dbg_sel  in  2  debug register-file read index.
- dbg_data  out  4  rf[dbg_sel], combinational.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE and all rf entries clear to 0.
  - Instruction latch clears (op=000, indices 0, imm 0).
  - res_f=0, res_zero=0, res_overflow=0, res_err=0, res_valid=0; in_ready=1 after release.
  - Reset mid-instruction abandons it with no writeback.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1 and res_valid=0.
  - On in_valid=1 at a clock edge, latch op/rd/rs/rt/imm and go to EXEC.
  - in_valid=0 holds IDLE.
- EXEC (exactly one cycle):
  - in_ready=0.
  - alu_a=rf[rs_l] and alu_b=rf[rt_l], combinational from the register file and latched indices.
  - alu_op=op_l for ALU ops; for LDI or illegal opcodes alu_op=000.
  - At the edge leaving EXEC:
    - ALU op: rf[rd_l]<=alu_f, res_f<=alu_f, res_zero<=alu_zero, res_overflow<=alu_overflow, res_err<=0.
    - LDI: rf[rd_l]<=imm_l, res_f<=imm_l, res_zero<=(imm_l==0), res_overflow<=0, res_err<=0.
    - Illegal (100/101): no rf write, res_f<=0, res_zero<=0, res_overflow<=0, res_err<=1.
  - Then go to DONE.
- DONE:
  - res_valid=1 and in_ready=0; res_* are held stable.
  - On res_ready=1 at an edge, go to IDLE; res_* keep their values, res_valid drops.
  - res_ready=0 holds DONE indefinitely.
  - res_ready is ignored outside DONE.
- Outside EXEC: alu_a/alu_b still follow rf[rs_l]/rf[rt_l], and alu_op=000. The ALU output is don't-care there.
- Latency and throughput:
  - Accept edge to res_valid high is 2 edges.
  - With res_ready tied high, back-to-back instructions are accepted every 3 cycles.
- Arithmetic: 4-bit wrap-around is performed by the ALU.
  - res_overflow is the ALU's 5th bit: carry-out for ADD, borrow for SUB.
  - SLT is an unsigned compare.
- Hazards:
  - rd equal to rs or rt reads the old value in EXEC and writes the new one at the end of EXEC.
  - The next instruction sees the updated value; no forwarding is needed.
- dbg_data reflects rf writes from the edge after EXEC.

Test Plan:
- Reset then dbg_sel sweep 0..3 -> dbg_data=0 for all; in_ready=1, res_valid=0, res_* all 0.
- LDI r1=9, LDI r2=8, ADD r3=r1+r2 (res_ready=1) -> ADD: alu_a=9, alu_b=8, alu_op=010 in EXEC; res_f=1, res_overflow=1, res_zero=0; r3=1.
- SUB r0=r2-r1 with r1=9, r2=8 -> res_f=15, res_overflow=1; SUB r0=r1-r1 -> res_f=0, res_zero=1.
- SLT r3=r2<r1 -> res_f=1; AND r3 with r1=9, r2=8 -> res_f=8; OR of 0x5 and 0xA -> res_f=15; back-to-back with res_ready high -> in_ready pulses every 3rd cycle.
- Illegal op 100 with rd=1 -> res_err=1, res_f=0, r1 unchanged; alu_op stays 000 throughout.
- Hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1, in_ready=0, in_valid ignored, res_* stable. Separately, assert rst_n=0 during EXEC -> no writeback and immediate return to IDLE state values.
